// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_pkg;

    // Arbiter FSM: pick an owner, hold the bus, then one forced dead cycle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Direction encoding seen by the memory.
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Width of a master index; at least one bit so a 1-master build still elaborates.
    function automatic int owner_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Combinational round-robin search: first requester at or after the pointer,
// scanning upward and wrapping at N so nonexistent indices are never chosen.
module rr_pick
    import bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int OW = owner_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [OW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [OW-1:0] o_idx,
    output logic          o_any
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin : search
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = OW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and bus mux: N cores share one memory port through the
// grant_request/grant_given handshake, with an optional tenure limit.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int MAX_HOLD  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          grant_request,
    output logic [N_MASTERS-1:0]          grant_given,
    input  logic [N_MASTERS-1:0]          m_rw,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data_out,
    output logic [DATA_W-1:0]             m_data_in,
    output logic                          mem_en,
    output logic                          mem_rw,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [owner_w(N_MASTERS)-1:0] owner_id,
    output logic                          timeout
);

    localparam int OW = owner_w(N_MASTERS);
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [OW-1:0] LAST_IDX = OW'(N_MASTERS - 1);

    arb_state_t             r_state;
    logic [N_MASTERS-1:0]   r_grant;
    logic [OW-1:0]          r_owner;    // visible owner, zero when idle
    logic [OW-1:0]          r_last;     // owner of the latest tenure, kept for the pointer
    logic [OW-1:0]          r_ptr;
    logic [HOLD_W-1:0]      r_hold;
    logic                   r_timeout;

    logic [N_MASTERS-1:0]   w_pick;
    logic [OW-1:0]          w_idx;
    logic                   w_any;
    logic                   w_own_req;
    logic                   w_rw;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_wdata;

    rr_pick #(
        .N  (N_MASTERS),
        .OW (OW)
    ) u_pick (
        .i_req (grant_request),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Only the current owner's request matters; others are ignored while granted.
    assign w_own_req = |(grant_request & r_grant);

    // Arbitration FSM with registered grant, owner, timeout and tenure counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_last    <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_owner <= w_idx;
                        r_last  <= w_idx;
                        r_hold  <= HOLD_W'(1);
                        r_state <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!w_own_req) begin
                        r_grant <= '0;
                        r_owner <= '0;
                        r_state <= RELEASE;
                    end else if ((MAX_HOLD != 0) && (r_hold == HOLD_LIM)) begin
                        r_grant   <= '0;
                        r_owner   <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RELEASE;
                    end else if ((MAX_HOLD != 0) && (r_hold != HOLD_LIM)) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                RELEASE: begin
                    // Last owner drops to lowest priority for the next pick.
                    r_ptr   <= (r_last == LAST_IDX) ? '0 : r_last + 1'b1;
                    r_hold  <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // One-hot AND-OR mux from the registered grant; all zero when idle.
    always_comb begin
        w_rw    = RW_READ;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_rw    = w_rw | m_rw[i];
                w_addr  = w_addr | m_address[i*ADDR_W +: ADDR_W];
                w_wdata = w_wdata | m_data_out[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_given = r_grant;
    assign owner_id    = r_owner;
    assign timeout     = r_timeout;
    assign mem_en      = |r_grant;
    assign mem_rw      = w_rw;
    assign mem_address = w_addr;
    assign mem_wdata   = w_wdata;
    assign m_data_in   = mem_rdata;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: expected grant order is queued by each
// scenario and popped by a monitor whenever a new tenure starts.
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int MH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    rw = '0;
    logic [N-1:0]    gnt;
    logic [N*AW-1:0] maddr = '0;
    logic [N*DW-1:0] mdata = '0;
    logic [DW-1:0]   rdata = 8'h5A;
    logic [DW-1:0]   din;
    logic [DW-1:0]   wdata;
    logic            men;
    logic            mrw;
    logic            tmo;
    logic [AW-1:0]   addr;
    logic [1:0]      oid;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int tenures = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_HOLD  (MH)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .grant_request (req),
        .grant_given   (gnt),
        .m_rw          (rw),
        .m_address     (maddr),
        .m_data_out    (mdata),
        .m_data_in     (din),
        .mem_en        (men),
        .mem_rw        (mrw),
        .mem_address   (addr),
        .mem_wdata     (wdata),
        .mem_rdata     (rdata),
        .owner_id      (oid),
        .timeout       (tmo)
    );

    // Monitor: scoreboard pop on each new tenure, plus mux/timeout reference model.
    logic [N-1:0] prev_gnt = '0;
    logic         prev_req_own = 1'b0;
    int           tlen = 0;
    always @(negedge clk) begin : monitor
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          er;
        logic [1:0]    eo;
        logic          et;
        logic [N-1:0]  eg;
        int            e;
        if (rst_n) begin
            ea = '0; ed = '0; er = 1'b0; eo = '0;
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    ea = maddr[i*AW +: AW];
                    ed = mdata[i*DW +: DW];
                    er = rw[i];
                    eo = 2'(i);
                end
            end
            if (gnt != '0 && prev_gnt == '0) begin
                tlen = 1;
                tenures++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL grant_order: unexpected grant %b at %0t", gnt, $time);
                end else begin
                    e = exp_q.pop_front();
                    eg = '0;
                    eg[e] = 1'b1;
                    if (gnt !== eg) begin
                        errors++;
                        $display("FAIL grant_order: got %b expected %b at %0t", gnt, eg, $time);
                    end
                end
            end else if (gnt != '0) begin
                tlen++;
            end
            checks++;
            if (!$onehot0(gnt) || (prev_gnt != '0 && gnt != '0 && gnt != prev_gnt)) begin
                errors++;
                $display("FAIL grant_overlap: prev %b now %b at %0t", prev_gnt, gnt, $time);
            end
            et = (prev_gnt != '0 && gnt == '0 && tlen == MH && prev_req_own);
            checks++;
            if ({men, mrw, addr, wdata, oid, tmo} !== {|gnt, er, ea, ed, eo, et}) begin
                errors++;
                $display("FAIL datapath: en/rw/addr/wd/id/to got %b %b %h %h %0d %b expected %b %b %h %h %0d %b at %0t",
                         men, mrw, addr, wdata, oid, tmo, |gnt, er, ea, ed, eo, et, $time);
            end
            checks++;
            if (din !== rdata) begin
                errors++;
                $display("FAIL rdata_bcast: got %h expected %h", din, rdata);
            end
        end
        prev_gnt = gnt;
        prev_req_own = |(req & gnt);
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({gnt, men, oid, tmo, addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt %b en %b id %0d to %b addr %h, expected all 0", gnt, men, oid, tmo, addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        maddr = {9'h0F0, 9'h033, 9'h1A5, 9'h111};
        mdata = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0010;
        exp_q.push_back(1);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || oid !== 2'd1 || addr !== 9'h1A5) begin
            errors++;
            $display("FAIL single_req: gnt %b id %0d addr %h expected 0010 1 1a5", gnt, oid, addr);
        end
        @(posedge clk); #1;
        req = '0;
        settle();
    endtask

    task automatic test_round_robin();
        int cnt[N];
        logic [N-1:0] rr;
        int base;
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        rr = '0;
        maddr = {9'h1C0, 9'h0B0, 9'h0A0, 9'h090};
        rdata = 8'hA7;
        base = tenures;
        for (int i = 0; i < 5; i++) exp_q.push_back(i % N);
        req = '1;
        for (int cyc = 0; cyc < 200 && (tenures - base) < 5; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (rr[i]) begin
                    req[i] = 1'b1;
                    rr[i] = 1'b0;
                end
                if (gnt[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 3) begin
                        req[i] = 1'b0;
                        rr[i] = 1'b1;
                        cnt[i] = 0;
                    end
                end
            end
        end
        checks++;
        if ((tenures - base) < 5) begin
            errors++;
            $display("FAIL rr_budget: saw %0d tenures expected 5", tenures - base);
        end
        @(posedge clk); #1;
        req = '0;
        settle();
    endtask

    task automatic test_forced_release();
        int n;
        bit seen;
        bit done;
        do_reset();
        rw = 4'b1000;
        maddr = {9'h0FF, 9'h055, 9'h022, 9'h011};
        mdata = {8'hC3, 8'h3C, 8'h22, 8'h11};
        exp_q.push_back(2);
        exp_q.push_back(3);
        req = 4'b1100;
        n = 0; seen = 0; done = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (gnt[2]) begin
                n++;
                seen = 1;
            end else if (seen) begin
                done = 1;
                checks++;
                if (n !== MH || tmo !== 1'b1) begin
                    errors++;
                    $display("FAIL forced_release: held %0d timeout %b expected %0d 1", n, tmo, MH);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL forced_release: no release within budget, held %0d", n);
        end
        @(negedge clk);
        checks++;
        if (gnt !== '0 || tmo !== 1'b0 || men !== 1'b0) begin
            errors++;
            $display("FAIL dead_cycle: gnt %b to %b en %b expected 0 0 0", gnt, tmo, men);
        end
        for (int cyc = 0; cyc < 10 && !gnt[3]; cyc++) @(negedge clk);
        checks++;
        if ({gnt, men, mrw, addr, wdata} !== {4'b1000, 1'b1, 1'b1, 9'h0FF, 8'hC3}) begin
            errors++;
            $display("FAIL write_mux: gnt %b en %b rw %b addr %h wd %h expected 1000 1 1 0ff c3",
                     gnt, men, mrw, addr, wdata);
        end
        @(posedge clk); #1;
        req = '0;
        rw = '0;
        settle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        maddr = {9'h004, 9'h003, 9'h002, 9'h101};
        req = 4'b0001;
        exp_q.push_back(0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL mid_pre: gnt %b expected 0001", gnt);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || men !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt %b en %b expected 0 0", gnt, men);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (gnt !== '0 || men !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: gnt %b en %b expected 0 0", gnt, men);
            end
        end
        @(posedge clk); #1;
        req = 4'b0101;
        exp_q.push_back(0);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5 && gnt == '0; cyc++) @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_ptr: gnt %b expected 0001", gnt);
        end
        @(posedge clk); #1;
        req = '0;
        settle();
    endtask

    task automatic test_idle();
        maddr = {9'h1FF, 9'h0AA, 9'h155, 9'h0F0};
        mdata = {8'hFF, 8'hAA, 8'h55, 8'h0F};
        rw = '1;
        req = '0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if ({gnt, men, mrw, addr, wdata, tmo} !== '0) begin
                errors++;
                $display("FAIL idle_bus: gnt %b en %b rw %b addr %h wd %h to %b expected all 0",
                         gnt, men, mrw, addr, wdata, tmo);
            end
        end
        rw = '0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_forced_release();
        test_reset_mid();
        test_idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected grants never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised round-robin arbiter and bus mux: N cores share one memory port using the grant_request/grant_given handshake the core already uses.
- Generalises the single-master arrangement to N masters, configurable address and data widths, and an optional maximum-tenure limit with forced release.
- Sits between the core instances and the shared memory, one level above each core.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- ADDR_W, 9, address width.
- DATA_W, 8, data width.
- MAX_HOLD, 16, maximum consecutive granted cycles per tenure; 0 disables the limit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- grant_request  in  N_MASTERS  per-master bus request.
- grant_given  out  N_MASTERS  one-hot (or zero) grant.
- m_rw  in  N_MASTERS  per-master direction, 1=write, 0=read.
- m_address  in  N_MASTERS*ADDR_W  packed master addresses; master i occupies slice i.
- m_data_out  in  N_MASTERS*DATA_W  packed master write data.
- m_data_in  out  DATA_W  read data broadcast to all masters.
- mem_en  out  1  memory access strobe.
- mem_rw  out  1  muxed direction.
- mem_address  out  ADDR_W  muxed address.
- mem_wdata  out  DATA_W  muxed write data.
- mem_rdata  in  DATA_W  memory read data.
- owner_id  out  $clog2(N_MASTERS)  index of current owner; 0 when idle.
- timeout  out  1  one-cycle pulse when a tenure is force-released.

Behaviour:
- Reset values: grant_given=0, owner_id=0, timeout=0, mem_en=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- Reset is asynchronous and may be asserted mid-tenure: the grant drops immediately and no further mem_en is issued.
- The FSM has three states: IDLE, GRANTED and RELEASE.
- IDLE:
  - If any request is set, pick the first requester at or after rr_ptr, searching upward with wrap modulo N_MASTERS.
  - Register the grant. grant_given rises on the edge after the request is sampled, so request-to-grant latency is 1 cycle.
  - Go to GRANTED with hold_cnt=1.
- GRANTED:
  - Owner deasserts request: grant drops next edge; go to RELEASE.
  - hold_cnt reaches MAX_HOLD (MAX_HOLD≠0) while the request is still high: grant drops next edge, timeout pulses 1 cycle with the drop; go to RELEASE.
  - Otherwise hold_cnt increments and saturates at MAX_HOLD.
- RELEASE:
  - This is one dead cycle with all grants 0 and mem_en=0, so no back-to-back owner overlap.
  - rr_ptr becomes (owner+1) mod N_MASTERS; return to IDLE.
- A force-released master whose request is still high re-enters arbitration normally. The pointer advance gives it lowest priority.
- Datapath (combinational from registered grant):
  - mem_en = |grant_given.
  - mem_rw, mem_address and mem_wdata come from the owner's slice.
  - When idle, mem_address and mem_wdata are 0 and mem_rw=0.
  - m_data_in = mem_rdata always.
- Requests from non-owners during GRANTED are ignored, not latched. A request raised and dropped while another master owns the bus is lost.
- A simultaneous request from all masters in IDLE grants rr_ptr's master.
- N_MASTERS not a power of two: the wrap skips nonexistent indices.
- The worst-case wait for any continuously requesting master is bounded by (N_MASTERS-1)*(MAX_HOLD+2) cycles.

Decomposition:
- Package bus_pkg holds:
  - the arb_state_t enum (IDLE, GRANTED, RELEASE);
  - the OWNER_W = $clog2(N_MASTERS) helper function;
  - the RW_WRITE/RW_READ constants.
- One sub-module, rr_pick: combinational priority search taking request vector and pointer and returning a one-hot grant plus index.
- The FSM, counters and mux stay in bus_arbiter_rr.

Test Plan:
- Single request: reset released, grant_request=4'b0010 at cycle 0 -> grant_given=4'b0010 and owner_id=1 at cycle 1; mem_address equals master 1 slice (9'h1A5).
- Round-robin order: all four request continuously, MAX_HOLD=0; each drops its request after 3 granted cycles and re-raises it 1 cycle later -> grant order 0,1,2,3,0 with one dead cycle between each.
- Forced release: master 2 holds its request with MAX_HOLD=16 -> grant high exactly 16 cycles, timeout=1 on the drop cycle, then a one-cycle gap. With master 3 requesting, master 3 gets the next grant.
- Write mux: master 3 owner with m_rw=1, addr 9'h0FF, data 8'hC3 -> mem_en=1, mem_rw=1, mem_address=9'h0FF, mem_wdata=8'hC3. Non-owner values are never visible.
- Reset mid-tenure: reset driven to 0 during master 0's tenure, between clock edges -> grant_given=0 and mem_en=0 without waiting for an edge. After release, a request from master 0 is granted first (rr_ptr=0).
- Idle bus: no requests for 20 cycles -> grant_given=0, mem_en=0, mem_address=0, timeout never pulses.
